// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host frame receiver folding E0/F0 prefixes into flags on scan-code events
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        r_state, w_state_n;
    logic          r_clk_s1, r_clk_s2, r_clk_s3, r_dat_s1, r_dat_s2;
    logic [2:0]    r_bitcnt, w_bitcnt_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_par, w_par_n;
    logic          r_ext, w_ext_n, r_brk, w_brk_n;
    logic [TW-1:0] r_tcnt, w_tcnt_n;
    logic [7:0]    r_code, w_code_n;
    logic          r_extended, w_extended_n, r_released, w_released_n;
    logic          r_valid, w_valid_n, r_err, w_err_n;
    logic          w_fall, w_good;

    assign w_fall     = r_clk_s3 & ~r_clk_s2;
    assign w_good     = r_dat_s2 & (^r_shift ^ r_par);
    assign code       = r_code;
    assign extended   = r_extended;
    assign released   = r_released;
    assign code_valid = r_valid;
    assign frame_err  = r_err;

    // Two-flop synchronisers on both pins plus a third clock flop for falling-edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r_clk_s1, r_clk_s2, r_clk_s3} <= 3'b000;
            {r_dat_s1, r_dat_s2}           <= 2'b00;
        end else begin
            {r_clk_s1, r_clk_s2, r_clk_s3} <= {PS2_clk, r_clk_s1, r_clk_s2};
            {r_dat_s1, r_dat_s2}           <= {PS2_data, r_dat_s1};
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_tcnt     <= '0;
            r_code     <= '0;
            r_extended <= 1'b0;
            r_released <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bitcnt   <= w_bitcnt_n;
            r_shift    <= w_shift_n;
            r_par      <= w_par_n;
            r_ext      <= w_ext_n;
            r_brk      <= w_brk_n;
            r_tcnt     <= w_tcnt_n;
            r_code     <= w_code_n;
            r_extended <= w_extended_n;
            r_released <= w_released_n;
            r_valid    <= w_valid_n;
            r_err      <= w_err_n;
        end
    end

    // Next-state: deserialise on each falling edge, decode at the stop bit, abort stalled frames
    always_comb begin
        w_state_n    = r_state;
        w_bitcnt_n   = r_bitcnt;
        w_shift_n    = r_shift;
        w_par_n      = r_par;
        w_ext_n      = r_ext;
        w_brk_n      = r_brk;
        w_code_n     = r_code;
        w_extended_n = r_extended;
        w_released_n = r_released;
        w_valid_n    = 1'b0;
        w_err_n      = 1'b0;
        w_tcnt_n     = (w_fall || r_state == IDLE) ? '0 : (r_tcnt == TMAX ? r_tcnt : r_tcnt + 1'b1);
        case (r_state)
            IDLE: if (w_fall && !r_dat_s2) begin
                w_state_n  = DATA;
                w_bitcnt_n = '0;
            end
            DATA: if (w_fall) begin
                w_shift_n  = {r_dat_s2, r_shift[7:1]};
                w_bitcnt_n = r_bitcnt + 3'd1;
                w_state_n  = (r_bitcnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: if (w_fall) begin
                w_par_n   = r_dat_s2;
                w_state_n = STOP;
            end
            default: if (w_fall) begin
                w_state_n = IDLE;
                if (!w_good) begin
                    w_err_n = 1'b1;
                    w_ext_n = 1'b0;
                    w_brk_n = 1'b0;
                end else if (r_shift == 8'hE0) begin
                    w_ext_n = 1'b1;
                end else if (r_shift == 8'hF0) begin
                    w_brk_n = 1'b1;
                end else begin
                    w_code_n     = r_shift;
                    w_extended_n = r_ext;
                    w_released_n = r_brk;
                    w_valid_n    = 1'b1;
                    w_ext_n      = 1'b0;
                    w_brk_n      = 1'b0;
                end
            end
        endcase
        if (r_state != IDLE && !w_fall && r_tcnt == TMAX) begin
            w_state_n = IDLE;
            w_err_n   = 1'b1;
            w_ext_n   = 1'b0;
            w_brk_n   = 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames with a queue-based scoreboard checking every output pulse
module tb_ps2_scancode_rx;
    localparam int TO = 200;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       PS2_clk = 1'b1;
    logic       PS2_data = 1'b1;
    logic [7:0] code;
    logic       extended, released, code_valid, frame_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
        .code(code), .extended(extended), .released(released),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    // Expected entry layout: {frame_err, code_valid, code, extended, released}
    task automatic exp_code(input logic [7:0] c, input logic e, input logic r);
        exp_q.push_back({1'b0, 1'b1, c, e, r});
    endtask

    task automatic exp_err(input logic [7:0] c, input logic e, input logic r);
        exp_q.push_back({1'b1, 1'b0, c, e, r});
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        PS2_data = b;
        repeat (H) @(negedge clk);
        PS2_clk = 1'b0;
        repeat (H) @(negedge clk);
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop);
        PS2_data = 1'b1;
        repeat (30) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic stall_partial(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        PS2_data = 1'b1;
        repeat (TO - 40) @(negedge clk);
        chk("early_timeout", exp_q.size(), 1);
        repeat (TO / 5 + 20) @(negedge clk);
        chk("timeout_seen", exp_q.size(), 0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && (code_valid || frame_err)) begin
            chk("both_pulses", int'(code_valid & frame_err), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'({frame_err, code_valid, code, extended, released}), 0);
            end else begin
                chk("event", int'({frame_err, code_valid, code, extended, released}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({code, extended, released, code_valid, frame_err}), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_quiet", int'({code_valid, frame_err}), 0);

        exp_code(8'h1D, 1'b0, 1'b0); send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        exp_code(8'h1D, 1'b0, 1'b1); send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        exp_code(8'h6B, 1'b1, 1'b1); send_frame(8'h6B, 1'b0, 1'b1);
        exp_code(8'h1C, 1'b0, 1'b0); send_frame(8'h1C, 1'b0, 1'b1);
        exp_err(8'h1C, 1'b0, 1'b0);  send_frame(8'h1D, 1'b1, 1'b1);
        exp_code(8'h23, 1'b0, 1'b0); send_frame(8'h23, 1'b0, 1'b1);

        exp_err(8'h23, 1'b0, 1'b0);  stall_partial(8'h1D);
        exp_code(8'h1D, 1'b0, 1'b0); send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        exp_err(8'h1D, 1'b0, 1'b0);  stall_partial(8'h6B);
        exp_code(8'h6B, 1'b0, 1'b0); send_frame(8'h6B, 1'b0, 1'b1);

        send_frame(8'hF0, 1'b0, 1'b1);
        repeat (2 * TO) @(negedge clk);
        exp_code(8'h74, 1'b0, 1'b1); send_frame(8'h74, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        exp_err(8'h74, 1'b0, 1'b1);  send_frame(8'h5A, 1'b0, 1'b0);
        exp_code(8'h72, 1'b0, 1'b0); send_frame(8'h72, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        exp_code(8'h75, 1'b1, 1'b1); send_frame(8'h75, 1'b0, 1'b1);

        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_mid_frame", int'({code, extended, released, code_valid, frame_err}), 0);
        end
        rst = 1'b1;
        PS2_data = 1'b1;
        repeat (TO + 50) @(negedge clk);
        chk("no_partial_pulse", exp_q.size(), 0);
        exp_code(8'h29, 1'b0, 1'b0); send_frame(8'h29, 1'b0, 1'b1);

        repeat (50) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 device-to-host frame receiver; sits directly upstream of keyboard_input and turns the raw PS2_clk/PS2_data pins into decoded scan-code events.
- Synchronises both PS/2 lines into the 50 MHz system domain and deserialises 11-bit frames.
- Folds the E0 (extended) and F0 (break) prefixes into flags on the following code.
- Emits one single-cycle event per key make/break, and flags malformed or stalled frames.

Parameters:
TIMEOUT_CYCLES, 50000, system clocks with no PS2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  reset, asynchronous, active-low.
PS2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
PS2_data  input  1  raw PS/2 data pin, asynchronous to clk.
code  output  8  last decoded scan code; held between events.
extended  output  1  code was preceded by E0; held with code.
released  output  1  code was preceded by F0 (break); held with code.
code_valid  output  1  one-cycle pulse when code/extended/released update.
frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM in IDLE, bit counter 0, shift register 0, ext/brk prefix flags 0, timeout counter 0. Reset asserted mid-frame discards the partial frame; no pulse is issued.
- Synchronisers: PS2_clk and PS2_data each pass through 2 flops. A third flop on PS2_clk gives edge detect.
- fall = (sync_clk_prev==1 && sync_clk==0). PS2_data is sampled only in the cycle fall=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit) -> DATA, bit counter=0. On fall with data=1 -> stay IDLE; no error.
  - DATA: on each fall, shift the data bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: on fall, store the bit -> STOP.
  - STOP: on fall -> IDLE. The frame is good iff the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
- Good frame, cycle after the stop-bit fall:
  - byte E0: set ext flag; no code_valid.
  - byte F0: set brk flag; no code_valid.
  - any other byte: code=byte, extended=ext, released=brk, code_valid=1 for exactly one cycle; clear ext and brk in the same cycle.
- Bad frame (parity or stop error): frame_err=1 for one cycle, cycle after the stop-bit fall. No code_valid. ext and brk cleared; code/extended/released unchanged.
- Timeout:
  - Counter clears on every fall and while in IDLE; otherwise increments, saturating.
  - When the FSM is not IDLE and the counter reaches TIMEOUT_CYCLES: FSM -> IDLE, frame_err pulse, ext and brk cleared.
  - A prefix followed by idle lines does not time out; the prefix is kept until the next frame.
- Latency: code_valid rises 1 clk after the cycle in which the stop-bit fall is detected, i.e. ≤4 clk after the pin edge.
- Simultaneous events: a fall in the same cycle the timeout count is reached is processed as a fall (counter clears); no error.
- code_valid and frame_err are never both 1.
- E0 F0 in either order sets both flags.

Test Plan:
- Frame byte 0x1D (parity 1, stop 1) -> one code_valid pulse, code=0x1D, extended=0, released=0, frame_err stays 0.
- Frames F0,1D -> no pulse after F0; single pulse after 1D with code=0x1D, released=1, extended=0.
- Frames E0,F0,6B -> single pulse: code=0x6B, extended=1, released=1. The next frame 0x1C gives extended=0, released=0.
- Frame 0x1D with parity 0 -> frame_err pulse, no code_valid, outputs unchanged. A following good 0x23 decodes to code=0x23 with flags 0.
- Start bit plus 4 data bits, then both lines held high for 1.2 ms -> frame_err pulse ~1 ms after the last edge. A following good 0x1D decodes correctly. Repeat with E0 before the stall -> the flag is cleared.
- Assert rst for 3 clk mid-DATA (after 5 bits), release, send 0x29 -> all outputs 0 during reset; no pulse from the partial frame; one pulse with code=0x29.
